// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
//   Feeds words from a TX FIFO to an attached SPI master one transfer at a
//   time and collects the master's received words into an RX FIFO.
//   A watchdog aborts a transfer whose m_finish never arrives.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   tx_data/valid/ready  TX write side (push on tx_valid & tx_ready)
//   rx_data/valid/ready  RX read side, first-word-fall-through
//                        (pop on rx_valid & rx_ready)
//   m_data_in, m_start   word and one-cycle start pulse to the master
//   m_finish, m_data_out master finish pulse and received word
//   busy               high whenever the FSM is not IDLE
//   timeout_err        sticky watchdog-expiry flag, cleared only by reset
//   state_dbg_o        current FSM state, for observation only
//
// Handshake: a transfer on a valid/ready pair happens on a rising clk edge
// where both are high; valid never waits on ready, and data is held stable
// while valid is high and ready is low.

module spi_xfer_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty; wraps mod 2*DEPTH.
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Head word shows through while non-empty; zero when empty.
  assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

module spi_xfer_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] m_data_in,
  output logic                  m_start,
  input  logic                  m_finish,
  input  logic [DATA_WIDTH-1:0] m_data_out,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [1:0]            state_dbg_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] STORE = 2'd3;

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  // Watchdog value during the last permitted WAIT cycle.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [1:0]            state_q, state_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] m_data_in_q, m_data_in_d;
  logic                  m_start_q, busy_q;

  logic                  tx_pop, tx_full, tx_empty;
  logic [DATA_WIDTH-1:0] tx_head;
  logic                  rx_push, rx_full, rx_empty;

  spi_xfer_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (tx_valid),
    .wr_data_i (tx_data),
    .pop_i     (tx_pop),
    .rd_data_o (tx_head),
    .full_o    (tx_full),
    .empty_o   (tx_empty)
  );

  spi_xfer_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .push_i    (rx_push),
    .wr_data_i (m_data_out),
    .pop_i     (rx_ready),
    .rd_data_o (rx_data),
    .full_o    (rx_full),
    .empty_o   (rx_empty)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    err_d       = err_q;
    m_data_in_d = m_data_in_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    case (state_q)
      IDLE: begin
        // Starting only with RX space free guarantees the STORE push fits.
        if (!tx_empty && !rx_full) begin
          state_d     = START;
          tx_pop      = 1'b1;
          m_data_in_d = tx_head;
        end
      end
      START: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        if (m_finish) begin
          state_d = STORE;
          rx_push = 1'b1;
        end else if (wd_q == WD_LAST) begin
          // Abandon the transfer; its TX word is already gone.
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      STORE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      err_q       <= 1'b0;
      m_data_in_q <= '0;
      m_start_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      m_data_in_q <= m_data_in_d;
      m_start_q   <= (state_d == START);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign m_data_in   = m_data_in_q;
  assign m_start     = m_start_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign state_dbg_o = state_q;
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
module tb_spi_xfer_sequencer;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, t_rst;

  // main DUT (default timeout)
  logic [W-1:0] tx_data, rx_data, m_data_in, m_data_out;
  logic tx_valid, tx_ready, rx_valid, rx_ready, m_start, m_finish, busy, timeout_err;
  logic [1:0] state_dbg;

  // watchdog DUT (TIMEOUT_CYC = 15), master never finishes
  logic [W-1:0] t_tx_data, t_rx_data, t_m_data_in, t_m_data_out;
  logic t_tx_valid, t_tx_ready, t_rx_valid, t_rx_ready, t_m_start, t_m_finish, t_busy, t_err;
  logic [1:0] t_state;

  spi_xfer_sequencer u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .m_data_in(m_data_in),
    .m_start(m_start), .m_finish(m_finish), .m_data_out(m_data_out), .busy(busy),
    .timeout_err(timeout_err), .state_dbg_o(state_dbg)
  );

  spi_xfer_sequencer #(.TIMEOUT_CYC(15)) u_dut_to (
    .clk(clk), .rst(t_rst), .tx_data(t_tx_data), .tx_valid(t_tx_valid), .tx_ready(t_tx_ready),
    .rx_data(t_rx_data), .rx_valid(t_rx_valid), .rx_ready(t_rx_ready), .m_data_in(t_m_data_in),
    .m_start(t_m_start), .m_finish(t_m_finish), .m_data_out(t_m_data_out), .busy(t_busy),
    .timeout_err(t_err), .state_dbg_o(t_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];    // expected RX words
  logic [W-1:0] start_q[$];  // expected m_data_in per m_start
  int start_cnt = 0;
  bit model_chk = 1'b1;
  logic [W-1:0] mdl_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (m_start) begin
        start_cnt++;
        if (start_q.size() == 0) fail("start_unexpected");
        else check("start_data", m_data_in, start_q.pop_front());
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) fail("rx_unexpected");
        else check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- loopback master model ----------------
  initial begin
    m_finish = 1'b0;
    m_data_out = '0;
    forever begin
      @(negedge clk);
      if (m_start && !rst) begin
        mdl_d = m_data_in;
        repeat (19) @(posedge clk);
        #1;
        m_finish = 1'b1;
        m_data_out = ~mdl_d;
        @(posedge clk);
        #1;
        m_finish = 1'b0;
        if (model_chk) check("rx_valid_after_finish", rx_valid, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [W-1:0] d, input bit expect_rx);
    bit ok;
    int guard;
    guard = 0;
    tx_data = d;
    tx_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = tx_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 500);
    tx_valid = 1'b0;
    if (!ok) fail("push_timeout");
    else begin
      start_q.push_back(d);
      if (expect_rx) exp_q.push_back(~d);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int g = 0; g < 2000 && !done; g++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0 && start_q.size() == 0) done = 1'b1;
    end
    if (!done) fail(name);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_m_data_in"}, m_data_in, 0);
    check({tag, "_m_start"}, m_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] wrap_tbl [10] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54,
                                  8'h65, 8'h76, 8'h87, 8'h98, 8'hA9};
  int base;

  initial begin
    rst = 1'b1; t_rst = 1'b1;
    tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b1;
    t_tx_valid = 1'b0; t_tx_data = '0; t_rx_ready = 1'b1;
    t_m_finish = 1'b0; t_m_data_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0; t_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single word, start latency one cycle after push
    push_word(8'hA5, 1'b1);
    @(posedge clk);
    #1;
    check("single_m_start", m_start, 1);
    check("single_m_data_in", m_data_in, 8'hA5);
    check("single_busy", busy, 1);
    wait_idle("single_drain");
    check("single_rx_empty", rx_valid, 0);

    // burst of four
    base = start_cnt;
    push_word(8'h01, 1'b1);
    push_word(8'h02, 1'b1);
    push_word(8'h03, 1'b1);
    push_word(8'h04, 1'b1);
    wait_idle("burst_drain");
    check("burst_start_count", start_cnt - base, 4);

    // RX backpressure
    rx_ready = 1'b0;
    base = start_cnt;
    for (int i = 0; i < 5; i++) push_word(8'hC0 + W'(i), 1'b1);
    check("bp_tx_full", tx_ready, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int g = 0; g < 500 && !seen; g++) begin
        @(posedge clk);
        #1;
        if (start_cnt - base == 4 && !busy) seen = 1'b1;
      end
      if (!seen) fail("bp_four_transfers");
    end
    repeat (30) @(posedge clk);
    #1;
    check("bp_start_count", start_cnt - base, 4);
    check("bp_busy", busy, 0);
    check("bp_rx_valid", rx_valid, 1);
    check("bp_tx_ready_one_left", tx_ready, 1);
    rx_ready = 1'b1;
    wait_idle("bp_drain");
    check("bp_final_count", start_cnt - base, 5);

    // reset in the middle of WAIT with words queued
    base = start_cnt;
    push_word(8'hB1, 1'b1);
    push_word(8'hB2, 1'b1);
    push_word(8'hB3, 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int g = 0; g < 50 && !seen; g++) begin
        @(posedge clk);
        #1;
        if (start_cnt > base) seen = 1'b1;
      end
      if (!seen) fail("rst_first_start");
    end
    repeat (5) @(posedge clk);
    #1;
    check("rst_in_wait", state_dbg, 2);
    model_chk = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    start_q.delete();
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = start_cnt;
    repeat (40) @(posedge clk);  // stale master finish lands in here
    #1;
    check("postrst_no_start", start_cnt - base, 0);
    check("postrst_rx_valid", rx_valid, 0);
    check("postrst_busy", busy, 0);
    check("postrst_tx_ready", tx_ready, 1);
    model_chk = 1'b1;

    // pointer wrap-around
    base = start_cnt;
    for (int i = 0; i < 10; i++) begin
      push_word(wrap_tbl[i], 1'b1);
      wait_idle("wrap_drain");
    end
    check("wrap_start_count", start_cnt - base, 10);

    // watchdog on the second instance
    t_tx_data = 8'h3C;
    t_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    t_tx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("to_m_start", t_m_start, 1);
    check("to_m_data_in", t_m_data_in, 8'h3C);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) begin
        check("to_err_before", t_err, 0);
        check("to_busy_before", t_busy, 1);
      end
      if (k == 16) begin
        check("to_err_set", t_err, 1);
        check("to_busy_after", t_busy, 0);
        check("to_state_idle", t_state, 0);
        check("to_rx_valid", t_rx_valid, 0);
        check("to_m_data_in_held", t_m_data_in, 8'h3C);
      end
    end
    // finish outside WAIT must be ignored
    t_m_finish = 1'b1;
    t_m_data_out = 8'h55;
    @(posedge clk);
    #1;
    t_m_finish = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("to_spurious_rx_valid", t_rx_valid, 0);
    check("to_err_sticky", t_err, 1);
    check("to_spurious_busy", t_busy, 0);
    t_rst = 1'b1;
    @(posedge clk);
    #1;
    check("to_err_cleared", t_err, 0);
    t_rst = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("start_q_empty", start_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
